// File: rtl/div_unit_pkg.sv
// Shared CPU definitions: datapath width, ALU operation encodings and the
// divider sequencer states.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU,
    ALU_DIV,
    ALU_DIVU
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_unit_div_step.sv
// One restoring-division step: shift in the next dividend bit and subtract
// the divisor, keeping the difference only when it is non-negative.
module div_step
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The partial remainder is always below the divisor, so the shifted value
  // fits in WIDTH+1 bits and the top bit of diff is the borrow.
  always_comb begin
    shifted = {rem_in, dividend_bit};
    diff    = shifted - {1'b0, divisor};
    q_bit   = ~diff[WIDTH];
    rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Iterative signed/unsigned divider: WIDTH restoring steps on magnitudes,
// then a sign-fixup cycle that publishes the result with a done pulse.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  div_state_t       state;
  logic [CNT_W-1:0] count;
  logic             steps_done;
  logic             neg_q;
  logic             neg_r;
  logic             zero_div;
  logic [WIDTH-1:0] orig_dividend;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] step_rem;
  logic             step_bit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in       (acc_r),
    .dividend_bit (acc_q[WIDTH-1]),
    .divisor      (dvsr),
    .rem_out      (step_rem),
    .q_bit        (step_bit)
  );

  // acc_q starts as the dividend magnitude and fills with quotient bits from
  // the right; the extra RUN cycle after the last step applies signs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      count         <= '0;
      steps_done    <= 1'b0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      zero_div      <= 1'b0;
      orig_dividend <= '0;
      dvsr          <= '0;
      acc_q         <= '0;
      acc_r         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      quotient      <= '0;
      remainder     <= '0;
      div_by_zero   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            state         <= RUN;
            count         <= '0;
            steps_done    <= 1'b0;
            neg_q         <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r         <= is_signed & dividend[WIDTH-1];
            zero_div      <= (divisor == '0);
            orig_dividend <= dividend;
            acc_q         <= (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
            dvsr          <= (is_signed && divisor[WIDTH-1]) ? -divisor : divisor;
            acc_r         <= '0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (!steps_done) begin
            busy  <= 1'b1;
            acc_q <= {acc_q[WIDTH-2:0], step_bit};
            acc_r <= step_rem;
            count <= (count == LAST) ? '0 : count + 1'b1;
            if (count == LAST) steps_done <= 1'b1;
          end else begin
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
            div_by_zero <= zero_div;
            if (zero_div) begin
              quotient  <= '1;
              remainder <= orig_dividend;
            end else begin
              quotient  <= neg_q ? -acc_q : acc_q;
              remainder <= neg_r ? -acc_r : acc_r;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
